lzss_decoder: RTL and testbench

Downstream stage of the LZSS encoder. Consumes the encoder's 11-bit codeword stream, rebuilds the original byte stream in a circular sliding window, and repacks it into 32-bit words in the same byte order the encoder ingests. Serves as the decompression path and as the loop-back checker for encoder verification.

---
 rtl/lzss_pkg.sv | 29 ++
 rtl/lzss_decoder_if.sv | 31 +++
 rtl/lzss_word_packer.sv | 57 +++++
 rtl/lzss_decoder.sv | 170 +++++++++++++++++
 tb/tb_lzss_decoder.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/lzss_pkg.sv
// lzss_pkg: definitions shared by the LZSS encoder/decoder slice.
//   - codeword field positions and widths (flag, literal, offset, length)
//   - decoder FSM state encoding
//   - default sliding-window depth
// No ports; imported with `import lzss_pkg::*;`.
package lzss_pkg;

    localparam int LZSS_WIN_DEPTH = 32;

    // 11-bit codeword layout.
    //   literal: [10]=0, [9:2]=byte,                 [1:0]=0
    //   match  : [10]=1, [9:5]=offset, [4:2]=length, [1:0]=0
    localparam int CW_W     = 11;
    localparam int FLAG_BIT = 10;
    localparam int LIT_LSB  = 2;
    localparam int LIT_W    = 8;
    localparam int OFF_LSB  = 5;
    localparam int OFF_W    = 5;
    localparam int LEN_LSB  = 2;
    localparam int LEN_W    = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COPY  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } dec_state_t;

endpackage

// File: rtl/lzss_decoder_if.sv
// lzss_decoder_if: codeword input and rebuilt-word output of the LZSS decoder.
//   codeword/cw_valid/enc_finish : from the encoder side
//   busy                         : decoder cannot take a codeword
//   data/data_valid/byte_num     : rebuilt 32-bit words, first byte in [7:0]
//
// Handshake: a codeword transfers on a rising edge where cw_valid=1 and
// busy=0; while busy=1 the source must hold or drop it. data_valid is a
// one-cycle strobe with no back-pressure: the sink must take data that cycle.
// enc_finish is a one-cycle pulse and needs no acknowledge.
interface lzss_decoder_if;
    import lzss_pkg::*;

    logic [CW_W-1:0] codeword;
    logic            cw_valid;
    logic            enc_finish;
    logic            busy;
    logic [31:0]     data;
    logic            data_valid;
    logic [2:0]      byte_num;

    modport master (
        output codeword, cw_valid, enc_finish,
        input  busy, data, data_valid, byte_num
    );

    modport slave (
        input  codeword, cw_valid, enc_finish,
        output busy, data, data_valid, byte_num
    );

endinterface

// File: rtl/lzss_word_packer.sv
// lzss_word_packer: collects bytes into 32-bit little-endian words.
//   clk, reset    : clock, synchronous active-high reset
//   push/push_byte: append one byte to the pack
//   flush         : emit a partial word (1..3 bytes) if the pack is non-empty
//   data          : packed word, first byte in [7:0], unused bytes 0
//   data_valid    : one-cycle strobe, data/byte_num hold until the next one
//   byte_num      : valid bytes in data (1..4)
//   empty         : pack currently holds no bytes
module lzss_word_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic [7:0]  push_byte,
    input  logic        flush,
    output logic [31:0] data,
    output logic        data_valid,
    output logic [2:0]  byte_num,
    output logic        empty
);

    logic [31:0] pack_q;
    logic [1:0]  cnt_q;

    assign empty = (cnt_q == 2'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            pack_q     <= '0;
            cnt_q      <= '0;
            data       <= '0;
            data_valid <= 1'b0;
            byte_num   <= '0;
        end else begin
            data_valid <= 1'b0;
            if (push) begin
                if (cnt_q == 2'd3) begin
                    // 4th byte goes straight to the output word.
                    data       <= {push_byte, pack_q[23:0]};
                    byte_num   <= 3'd4;
                    data_valid <= 1'b1;
                    pack_q     <= '0;
                    cnt_q      <= '0;
                end else begin
                    pack_q[{cnt_q, 3'b000} +: 8] <= push_byte;
                    cnt_q                        <= cnt_q + 2'd1;
                end
            end else if (flush && cnt_q != 2'd0) begin
                data       <= pack_q;
                byte_num   <= {1'b0, cnt_q};
                data_valid <= 1'b1;
                pack_q     <= '0;
                cnt_q      <= '0;
            end
        end
    end

endmodule

// File: rtl/lzss_decoder.sv
// lzss_decoder: rebuilds the byte stream from 11-bit LZSS codewords using a
// circular sliding window, and repacks it into 32-bit words.
//   clk, reset : clock, synchronous active-high reset
//   dec_if     : codeword in / busy / rebuilt words out (lzss_decoder_if.slave)
//   dec_num    : codewords consumed, saturating
//   finish     : stream fully flushed, held until reset
//   err        : sticky format error (only with LZSS_DEC_ERRCHK_EN, else 0)
//   state_dbg  : current FSM state
// Build option: define LZSS_DEC_ERRCHK_EN to flag L=0 matches and distances
// reaching past the bytes written so far.
module lzss_decoder
    import lzss_pkg::*;
#(
    parameter int WIN_DEPTH = LZSS_WIN_DEPTH,
    parameter int NUM_W     = 12
) (
    input  logic             clk,
    input  logic             reset,
    lzss_decoder_if.slave    dec_if,
    output logic [NUM_W-1:0] dec_num,
    output logic             finish,
    output logic             err,
    output dec_state_t       state_dbg
);

    localparam int AW = $clog2(WIN_DEPTH);

    dec_state_t       state_q, state_d;
    logic [7:0]       window_q [WIN_DEPTH];
    logic [AW-1:0]    wp_q;
    logic [OFF_W:0]   dist_q;
    logic [LEN_W-1:0] rem_q;
    logic             finish_pend_q;
    logic             busy_q;

    logic             cw_flag;
    logic [LIT_W-1:0] cw_lit;
    logic [OFF_W-1:0] cw_off;
    logic [LEN_W-1:0] cw_len;
    logic             accept;
    logic [AW-1:0]    rd_idx;
    logic             wr_en;
    logic [7:0]       wr_byte;
    logic             flush;
    logic             pack_empty;
    logic             unused_pad;

    assign cw_flag    = dec_if.codeword[FLAG_BIT];
    assign cw_lit     = dec_if.codeword[LIT_LSB +: LIT_W];
    assign cw_off     = dec_if.codeword[OFF_LSB +: OFF_W];
    assign cw_len     = dec_if.codeword[LEN_LSB +: LEN_W];
    assign unused_pad = ^dec_if.codeword[1:0];

    assign accept      = dec_if.cw_valid && !busy_q;
    assign dec_if.busy = busy_q;
    assign state_dbg   = state_q;

    // Distance 32 truncates to 0, which lands on the oldest byte: correct mod 32.
    assign rd_idx = wp_q - dist_q[AW-1:0];

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic. A codeword accepted alongside enc_finish wins; the
    // flush starts once the decoder is idle with nothing being accepted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (cw_flag && cw_len != '0) state_d = S_COPY;
                end else if (finish_pend_q || dec_if.enc_finish) begin
                    state_d = S_FLUSH;
                end
            end
            S_COPY:  if (rem_q == LEN_W'(1)) state_d = S_IDLE;
            S_FLUSH: state_d = S_DONE;
            default: state_d = S_DONE;
        endcase
    end

    // Output logic: window write / packer push and flush request
    always_comb begin
        wr_en   = 1'b0;
        wr_byte = '0;
        flush   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept && !cw_flag) begin
                    wr_en   = 1'b1;
                    wr_byte = cw_lit;
                end
            end
            S_COPY: begin
                wr_en   = 1'b1;
                wr_byte = window_q[rd_idx];
            end
            S_FLUSH: flush = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wp_q          <= '0;
            dist_q        <= '0;
            rem_q         <= '0;
            finish_pend_q <= 1'b0;
            busy_q        <= 1'b0;
            dec_num       <= '0;
            finish        <= 1'b0;
            for (int i = 0; i < WIN_DEPTH; i++) window_q[i] <= '0;
        end else begin
            busy_q <= (state_d != S_IDLE);
            if (dec_if.enc_finish) finish_pend_q <= 1'b1;
            if (accept && dec_num != '1) dec_num <= dec_num + 1'b1;
            if (state_q == S_IDLE && accept && cw_flag) begin
                dist_q <= {1'b0, cw_off} + 1'b1;
                rem_q  <= cw_len;
            end
            if (state_q == S_COPY) rem_q <= rem_q - 1'b1;
            if (wr_en) begin
                window_q[wp_q] <= wr_byte;
                wp_q           <= wp_q + 1'b1;
            end
            // A partial word leaves on the S_FLUSH edge; finish follows one
            // cycle later so it never coincides with the last data strobe.
            if ((state_q == S_FLUSH && pack_empty) || state_q == S_DONE)
                finish <= 1'b1;
        end
    end

`ifdef LZSS_DEC_ERRCHK_EN
    logic [AW:0] wr_cnt_q;
    logic        err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (wr_en && wr_cnt_q != (AW+1)'(WIN_DEPTH)) wr_cnt_q <= wr_cnt_q + 1'b1;
            if (state_q == S_IDLE && accept && cw_flag) begin
                if (cw_len == '0) err_q <= 1'b1;
                if ((int'(cw_off) + 1) > int'(wr_cnt_q)) err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    lzss_word_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .push       (wr_en),
        .push_byte  (wr_byte),
        .flush      (flush),
        .data       (dec_if.data),
        .data_valid (dec_if.data_valid),
        .byte_num   (dec_if.byte_num),
        .empty      (pack_empty)
    );

endmodule

// File: tb/tb_lzss_decoder.sv
// tb_lzss_decoder: directed bench for lzss_decoder.
module tb_lzss_decoder;
    import lzss_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lzss_decoder_if dif ();
    logic [11:0] dec_num;
    logic        finish;
    logic        err;
    dec_state_t  state_dbg;

    lzss_decoder #(.WIN_DEPTH(32), .NUM_W(12)) dut (
        .clk       (clk),
        .reset     (reset),
        .dec_if    (dif.slave),
        .dec_num   (dec_num),
        .finish    (finish),
        .err       (err),
        .state_dbg (state_dbg)
    );

    int errors = 0;
    int checks = 0;

    // scoreboard: {byte_num, data}
    logic [34:0] exp_q[$];
    logic [34:0] got_q[$];

    always @(negedge clk)
        if (!reset && dif.data_valid) got_q.push_back({dif.byte_num, dif.data});

    typedef struct {
        logic [10:0] cw;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic [2:0]  exp_bn;
        logic [11:0] exp_dec;
    } vec_t;

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"},     dif.busy,       0);
        check({tag, "_data"},     dif.data,       0);
        check({tag, "_dvalid"},   dif.data_valid, 0);
        check({tag, "_byte_num"}, dif.byte_num,   0);
        check({tag, "_dec_num"},  dec_num,        0);
        check({tag, "_finish"},   finish,         0);
        check({tag, "_err"},      err,            0);
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        dif.cw_valid   = 1'b0;
        dif.enc_finish = 1'b0;
        dif.codeword   = '0;
        tick();
        tick();
        reset = 1'b0;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic send(input logic [10:0] cw);
        int n = 0;
        while (dif.busy && n < 100) begin
            tick();
            n++;
        end
        if (dif.busy) check("send_busy_timeout", dif.busy, 0);
        dif.codeword = cw;
        dif.cw_valid = 1'b1;
        tick();
        dif.cw_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (dif.busy && n < 100) begin
            tick();
            n++;
        end
        check("wait_idle_timeout", dif.busy, 0);
    endtask

    task automatic pulse_finish();
        dif.enc_finish = 1'b1;
        tick();
        dif.enc_finish = 1'b0;
    endtask

    task automatic wait_finish();
        int n = 0;
        while (!finish && n < 30) begin
            tick();
            n++;
        end
        check("finish_timeout", finish, 1);
    endtask

    task automatic check_words(input string tag);
        int n;
        check({tag, "_nwords"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_w%0d_data", tag, i), got_q[i][31:0], exp_q[i][31:0]);
            check($sformatf("%s_w%0d_bn", tag, i), {29'd0, got_q[i][34:32]}, {29'd0, exp_q[i][34:32]});
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        vec_t vecs[8];
        int   bcnt;

        vecs[0] = '{11'h104, 1'b0, 32'h0,        3'd0, 12'd1};
        vecs[1] = '{11'h108, 1'b0, 32'h0,        3'd0, 12'd2};
        vecs[2] = '{11'h10C, 1'b0, 32'h0,        3'd0, 12'd3};
        vecs[3] = '{11'h110, 1'b1, 32'h44434241, 3'd4, 12'd4};
        vecs[4] = '{11'h184, 1'b0, 32'h44434241, 3'd4, 12'd5};
        vecs[5] = '{11'h188, 1'b0, 32'h44434241, 3'd4, 12'd6};
        vecs[6] = '{11'h18C, 1'b0, 32'h44434241, 3'd4, 12'd7};
        vecs[7] = '{11'h3FC, 1'b1, 32'hFF636261, 3'd4, 12'd8};

        // reset values (sampled while reset is held)
        reset          = 1'b1;
        dif.cw_valid   = 1'b0;
        dif.enc_finish = 1'b0;
        dif.codeword   = '0;
        tick();
        tick();
        check_reset_vals("rst");
        do_reset();

        // literal table: one codeword per cycle
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].cw);
            check($sformatf("lit%0d_valid", i), dif.data_valid, vecs[i].exp_valid);
            check($sformatf("lit%0d_data", i), dif.data, vecs[i].exp_data);
            check($sformatf("lit%0d_bn", i), dif.byte_num, vecs[i].exp_bn);
            check($sformatf("lit%0d_dec", i), dec_num, vecs[i].exp_dec);
        end

        // overlapping match + partial flush
        do_reset();
        send(11'h184);
        send(11'h414);
        bcnt = 0;
        while (dif.busy && bcnt < 20) begin
            bcnt++;
            tick();
        end
        check("ovl_busy_cycles", bcnt, 5);
        check("ovl_dec_num", dec_num, 2);
        exp_q.push_back({3'd4, 32'h61616161});
        pulse_finish();
        check("ovl_flush_busy", dif.busy, 1);
        check("ovl_flush_dv0", dif.data_valid, 0);
        check("ovl_flush_fin0", finish, 0);
        tick();
        check("ovl_part_dv", dif.data_valid, 1);
        check("ovl_part_fin", finish, 0);
        tick();
        check("ovl_fin", finish, 1);
        check("ovl_fin_dv", dif.data_valid, 0);
        exp_q.push_back({3'd2, 32'h00006161});
        check_words("ovl");

        // finish with empty pack; codewords ignored afterwards
        do_reset();
        pulse_finish();
        check("empty_c1_fin", finish, 0);
        check("empty_c1_busy", dif.busy, 1);
        tick();
        check("empty_c2_fin", finish, 1);
        dif.codeword = 11'h104;
        dif.cw_valid = 1'b1;
        tick();
        tick();
        tick();
        dif.cw_valid = 1'b0;
        check("empty_busy_held", dif.busy, 1);
        check("empty_dec_num", dec_num, 0);
        check("empty_fin_held", finish, 1);
        check_words("empty");

        // window wrap-around: 33 literals then dist 32, L=2
        do_reset();
        for (int i = 0; i <= 32; i++) begin
            logic [7:0] b;
            b = 8'(i);
            send({1'b0, b, 2'b00});
        end
        for (int w = 0; w < 8; w++) begin
            logic [7:0] b0;
            b0 = 8'(4 * w);
            exp_q.push_back({3'd4, b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0});
        end
        send(11'h7E8);
        wait_idle();
        pulse_finish();
        wait_finish();
        check("wrap_dec_num", dec_num, 34);
        exp_q.push_back({3'd3, 32'h00020120});
        check_words("wrap");

        // reset on the 3rd cycle of an L=7 copy
        do_reset();
        send(11'h104);
        send(11'h41C);
        tick();
        tick();
        check("mid_in_copy", dif.busy, 1);
        reset = 1'b1;
        tick();
        check_reset_vals("mid");
        reset = 1'b0;
        got_q.delete();
        check("mid_busy_after", dif.busy, 0);
        send(11'h104);
        pulse_finish();
        wait_finish();
        check("mid_dec_num", dec_num, 1);
        exp_q.push_back({3'd1, 32'h00000041});
        check_words("mid");

        // L=0 no-op and out-of-range distance
        do_reset();
        send(11'h420);
        check("l0_busy", dif.busy, 0);
        check("l0_dec_num", dec_num, 1);
`ifdef LZSS_DEC_ERRCHK_EN
        check("l0_err", err, 1);
`else
        check("l0_err", err, 0);
`endif
        send(11'h104);
        send(11'h444);
        wait_idle();
        send(11'h108);
        pulse_finish();
        wait_finish();
        check("oor_dec_num", dec_num, 4);
        exp_q.push_back({3'd3, 32'h00420041});
        check_words("oor");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
